// File: rtl/latch_bank_ctrl.sv
// Round-robin write sequencer for a bank of gated D-latches: setup -> gate -> hold -> ack.
// Optional read-back verify enabled by defining VERIFY_EN.
module latch_bank_ctrl #(
  parameter int unsigned N_LAT     = 4,
  parameter int unsigned W         = 8,
  parameter int unsigned SETUP_CYC = 1,
  parameter int unsigned GATE_CYC  = 2,
  parameter int unsigned HOLD_CYC  = 1,
  localparam int unsigned AW       = (N_LAT > 1) ? $clog2(N_LAT) : 1
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic [1:0]         i_req,
  input  logic [AW-1:0]      i_addr0,
  input  logic [AW-1:0]      i_addr1,
  input  logic [W-1:0]       i_data0,
  input  logic [W-1:0]       i_data1,
  output logic [1:0]         o_ack,
  output logic [W-1:0]       o_lat_d,
  output logic [N_LAT-1:0]   o_lat_gate,
  input  logic [N_LAT*W-1:0] i_lat_q,
  output logic               o_busy,
  output logic               o_err
);

  localparam int unsigned MAXC_SG = (SETUP_CYC > GATE_CYC) ? SETUP_CYC : GATE_CYC;
  localparam int unsigned MAXC    = (MAXC_SG > HOLD_CYC) ? MAXC_SG : HOLD_CYC;
  localparam int unsigned CW      = (MAXC > 1) ? $clog2(MAXC) : 1;

  typedef enum logic [2:0] {
    StIdle,
    StSetup,
    StGate,
    StHold,
    StCheck,
    StAck
  } state_e;

  state_e            r_state, w_state_d;
  logic [CW-1:0]     r_cnt, w_cnt_d;
  logic              r_last;
  logic              r_gnt;
  logic [AW-1:0]     r_addr;
  logic [W-1:0]      r_lat_d;
  logic [N_LAT-1:0]  r_gate, w_gate_d;
  logic [1:0]        r_ack, w_ack_d;
  logic              r_err;
  logic              w_grant;

  // Both requesting: the one not served last wins; r_last resets to 1 so requester 0 goes first.
  assign w_grant = (i_req == 2'b11) ? ~r_last : i_req[1];

  always_comb begin
    w_state_d = r_state;
    w_cnt_d   = r_cnt;
    unique case (r_state)
      StIdle: begin
        if (|i_req) begin
          w_state_d = StSetup;
          w_cnt_d   = CW'(SETUP_CYC - 1);
        end
      end
      StSetup: begin
        if (r_cnt == '0) begin
          w_state_d = StGate;
          w_cnt_d   = CW'(GATE_CYC - 1);
        end else begin
          w_cnt_d = r_cnt - 1'b1;
        end
      end
      StGate: begin
        if (r_cnt == '0) begin
          w_state_d = StHold;
          w_cnt_d   = CW'(HOLD_CYC - 1);
        end else begin
          w_cnt_d = r_cnt - 1'b1;
        end
      end
      StHold: begin
        if (r_cnt == '0) begin
`ifdef VERIFY_EN
          w_state_d = StCheck;
`else
          w_state_d = StAck;
`endif
        end else begin
          w_cnt_d = r_cnt - 1'b1;
        end
      end
      StCheck: w_state_d = StAck;
      StAck:   w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase
  end

  // Out-of-range addresses match no bit, so no gate asserts.
  always_comb begin
    w_gate_d = '0;
    if (w_state_d == StGate) begin
      for (int i = 0; i < int'(N_LAT); i++) begin
        w_gate_d[i] = (r_addr == AW'(i));
      end
    end
  end

  always_comb begin
    w_ack_d = 2'b00;
    if (w_state_d == StAck) begin
      w_ack_d = r_gnt ? 2'b10 : 2'b01;
    end
  end

`ifdef VERIFY_EN
  logic [W-1:0] w_word;
  logic         w_in_range;
  logic         w_mismatch;

  always_comb begin
    w_word     = '0;
    w_in_range = 1'b0;
    for (int i = 0; i < int'(N_LAT); i++) begin
      if (r_addr == AW'(i)) begin
        w_word     = i_lat_q[i*W +: W];
        w_in_range = 1'b1;
      end
    end
  end

  // r_lat_d still holds the captured write data during CHECK.
  assign w_mismatch = !w_in_range || (w_word != r_lat_d);
`else
  logic w_unused_lat_q;
  assign w_unused_lat_q = ^i_lat_q;
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= StIdle;
      r_cnt   <= '0;
      r_last  <= 1'b1;
      r_gnt   <= 1'b0;
      r_addr  <= '0;
      r_lat_d <= '0;
      r_gate  <= '0;
      r_ack   <= 2'b00;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_d;
      r_cnt   <= w_cnt_d;
      r_gate  <= w_gate_d;
      r_ack   <= w_ack_d;
      if ((r_state == StIdle) && (|i_req)) begin
        r_gnt   <= w_grant;
        r_last  <= w_grant;
        r_addr  <= w_grant ? i_addr1 : i_addr0;
        r_lat_d <= w_grant ? i_data1 : i_data0;
      end
`ifdef VERIFY_EN
      r_err <= (r_state == StCheck) && w_mismatch;
`else
      r_err <= 1'b0;
`endif
    end
  end

  assign o_ack      = r_ack;
  assign o_lat_d    = r_lat_d;
  assign o_lat_gate = r_gate;
  assign o_busy     = (r_state != StIdle);
  assign o_err      = r_err;

endmodule
